// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, start-bit validation at its mid-point,
// LSB-first data capture at bit mid-points, one-clk rx_done / frame_err pulses.
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rxd_s_q, rxd_s_d;
    logic          prev_s_q, prev_s_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    s_cnt_q, s_cnt_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_done_q, rx_done_d;
    logic          frame_err_q, frame_err_d;
    logic          s_tick;

    assign s_tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        sync1_d     = rxd;
        rxd_s_d     = sync1_q;
        prev_s_d    = rxd_s_q;
        // Tick generator is free-running; frames never realign it.
        div_cnt_d   = s_tick ? '0 : div_cnt_q + 1'b1;
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        n_d         = n_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev_s_q && !rxd_s_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == 4'd7) begin
                        if (!rxd_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == 4'd15) begin
                        shift_d = {rxd_s_q, shift_q[7:1]};
                        s_cnt_d = '0;
                        if (n_q == 3'd7) state_d = STOP;
                        else             n_d     = n_q + 3'd1;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == 4'd15) begin
                        if (rxd_s_q) begin
                            rx_data_d = shift_q;
                            rx_done_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            prev_s_q    <= 1'b1;
            div_cnt_q   <= '0;
            s_cnt_q     <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxd_s_q     <= rxd_s_d;
            prev_s_q    <= prev_s_d;
            div_cnt_q   <= div_cnt_d;
            s_cnt_q     <= s_cnt_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. It is the receive-side counterpart of the team's UART transmit path.
- Samples the asynchronous serial input at 16x the baud rate and validates the start bit at its mid-point. It then captures 8 data bits LSB-first at the mid-point of each bit and checks the stop bit.
- Delivers each byte with a one-cycle done pulse, and flags a framing error when the stop bit is low.
- Sits between the board RX pin and the downstream byte consumer (loopback/echo logic, FIFO).

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit period; fixed at 16, and the RTL may hard-code the mid/end tick indices from it.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- rxd  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  8  last correctly framed byte; holds until the next good frame.
- rx_done  output  1  one-clk pulse when rx_data is updated.
- frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; rx_data = 0x00; rx_done = 0; frame_err = 0; busy = 0.
  - Both synchronizer flops = 1, the prev-sample flop = 1, and all counters = 0.
  - Reset mid-frame abandons the frame immediately, with no done or error pulse.
- Input synchronizer:
  - Two flip-flop stages. rxd_s is the second stage and is the only form of rxd used internally.
  - prev_s is rxd_s delayed one clk.
- Sample tick generator:
  - Free-running counter over DIV = CLK_FREQ/(BAUD*OVERSAMPLE), using integer division (651 at the defaults).
  - s_tick pulses for one clk when the counter equals DIV-1, then the counter wraps to 0.
  - The generator never stops or realigns; start-edge phase uncertainty is at most 1 tick.
- State machine: IDLE, START, DATA, STOP. The tick count s_cnt is 4 bits; the bit count n is 3 bits.
- IDLE:
  - On the falling edge (prev_s = 1 and rxd_s = 0): go to START, s_cnt = 0.
  - A line held low with no preceding high, e.g. after a framing error or break, never starts a frame.
- START, evaluated on each s_tick:
  - If s_cnt = 7 (start-bit mid-point): if rxd_s = 0, go to DATA with s_cnt = 0 and n = 0; otherwise go to IDLE (glitch rejected, no outputs).
  - Else s_cnt + 1.
- DATA, evaluated on each s_tick:
  - If s_cnt = 15: shift_reg = {rxd_s, shift_reg[7:1]} (LSB-first), s_cnt = 0.
  - Then if n = 7 go to STOP, else n + 1.
  - Else s_cnt + 1.
- STOP, evaluated on each s_tick:
  - If s_cnt = 15 and rxd_s = 1: rx_data = shift_reg, rx_done = 1 for the next clk, go to IDLE.
  - If s_cnt = 15 and rxd_s = 0: frame_err = 1 for the next clk; rx_data unchanged; go to IDLE.
  - Else s_cnt + 1.
- Pulse rules:
  - rx_done and frame_err are registered, last exactly 1 clk, and are never high together.
- Latency:
  - rx_done rises about 9.5 bit periods after the rxd falling edge, at the stop-bit mid-point.
  - The exact delay is 2 clk of synchronizer delay plus 0 to 1 tick of phase uncertainty.
- Back-to-back frames:
  - IDLE is re-entered at the stop-bit mid-point.
  - The next start edge, which can arrive half a bit later, is detected without loss.
- busy:
  - Combinational from state: 1 in START, DATA and STOP.

Test Plan:
- Default parameters, send 0x55 (frame 0,1,0,1,0,1,0,1,0,1) -> exactly one rx_done pulse, rx_data = 0x55, frame_err = 0. The pulse occurs 989.6 us ± 7 us after the start edge.
- Test parameters CLK_FREQ=1_600_000, BAUD=10_000 (DIV=10): send 0xA3 then 0x00 then 0xFF back-to-back with no idle gap -> three rx_done pulses with rx_data 0xA3, 0x00, 0xFF in order.
- Low glitch on rxd lasting 3 ticks (30 clk at DIV=10), then line high -> busy pulses then returns to 0; no rx_done, no frame_err.
- Send 0x3C with stop bit driven 0, then hold rxd low for 20 bit times, then release -> one frame_err pulse, no rx_done, rx_data keeps the previous value. No new frame starts while the line is low. A subsequent 0x81 frame is received correctly.
- Assert reset at data bit 4 of a 0xC7 frame, release during the remaining bits, then send 0x5A after 2 idle bit times -> no pulses from the aborted frame; all outputs 0 during reset. 0x5A is received correctly.
- Frame 0x96 sent at BAUD +3% (receiver at nominal BAUD) -> rx_data = 0x96 with rx_done; at +6% drift, frame_err or wrong data is acceptable but there must be no hang: busy returns to 0 within 11 bit times.
